// File: rtl/vga_timing_pkg.sv
// Timing-mode record, the standard VGA modes and helpers that derive totals and sync windows.
// Shared by vga_timing_gen and any parent that picks a mode by name.
package vga_timing_pkg;

    typedef struct packed {
        logic [15:0] h_active;
        logic [15:0] h_front;
        logic [15:0] h_sync;
        logic [15:0] h_back;
        logic [15:0] v_active;
        logic [15:0] v_front;
        logic [15:0] v_sync;
        logic [15:0] v_back;
        logic        hs_pol;
        logic        vs_pol;
    } vga_mode_t;

    localparam vga_mode_t MODE_1024X768_60 = '{
        h_active: 16'd1024, h_front: 16'd24, h_sync: 16'd136, h_back: 16'd160,
        v_active: 16'd768,  v_front: 16'd3,  v_sync: 16'd6,   v_back: 16'd29,
        hs_pol:   1'b0,     vs_pol:  1'b0
    };

    localparam vga_mode_t MODE_640X480_60 = '{
        h_active: 16'd640, h_front: 16'd16, h_sync: 16'd96, h_back: 16'd48,
        v_active: 16'd480, v_front: 16'd10, v_sync: 16'd2,  v_back: 16'd33,
        hs_pol:   1'b0,    vs_pol:  1'b0
    };

    function automatic int h_total(input vga_mode_t m);
        return int'(m.h_active) + int'(m.h_front) + int'(m.h_sync) + int'(m.h_back);
    endfunction

    function automatic int v_total(input vga_mode_t m);
        return int'(m.v_active) + int'(m.v_front) + int'(m.v_sync) + int'(m.v_back);
    endfunction

    function automatic int hs_start(input vga_mode_t m);
        return int'(m.h_active) + int'(m.h_front);
    endfunction

    function automatic int hs_end(input vga_mode_t m);
        return int'(m.h_active) + int'(m.h_front) + int'(m.h_sync);
    endfunction

    function automatic int vs_start(input vga_mode_t m);
        return int'(m.v_active) + int'(m.v_front);
    endfunction

    function automatic int vs_end(input vga_mode_t m);
        return int'(m.v_active) + int'(m.v_front) + int'(m.v_sync);
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// DEPTH x WIDTH shift register advanced by i_en; latency DEPTH enabled ticks.
// No backpressure: i_en=0 freezes every stage; reset loads RESET_VAL into all stages.
module sync_delay_line #(
    parameter int                 DEPTH     = 1,
    parameter int                 WIDTH     = 1,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_dat,
    output logic [WIDTH-1:0] o_dat
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= RESET_VAL;
            end
        end else if (i_en) begin
            r_stage[0] <= i_dat;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_dat = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: beam counters, delayed valid/hsync/vsync (1+PIPE_DELAY pixel ticks), one-clk strobes.
// No backpressure: pix_en=0 freezes all state. Define VGA_TIMING_FRAME_CNT_EN to build the 16-bit frame counter.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = 1024,
    parameter int unsigned H_FRONT    = 24,
    parameter int unsigned H_SYNC     = 136,
    parameter int unsigned H_BACK     = 160,
    parameter int unsigned V_ACTIVE   = 768,
    parameter int unsigned V_FRONT    = 3,
    parameter int unsigned V_SYNC     = 6,
    parameter int unsigned V_BACK     = 29,
    parameter bit          HS_POL     = 1'b0,
    parameter bit          VS_POL     = 1'b0,
    parameter int unsigned PIPE_DELAY = 0,
    parameter int unsigned X_W        = 11,
    parameter int unsigned Y_W        = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           pix_en,
    output logic [X_W-1:0] beam_x,
    output logic [Y_W-1:0] beam_y,
    output logic           valid,
    output logic           hsync,
    output logic           vsync,
    output logic           line_start,
    output logic           frame_start,
    output logic           vblank_start,
    output logic [15:0]    frame_cnt
);

    localparam vga_mode_t C_MODE = '{
        h_active: 16'(H_ACTIVE), h_front: 16'(H_FRONT), h_sync: 16'(H_SYNC), h_back: 16'(H_BACK),
        v_active: 16'(V_ACTIVE), v_front: 16'(V_FRONT), v_sync: 16'(V_SYNC), v_back: 16'(V_BACK),
        hs_pol:   HS_POL,        vs_pol:  VS_POL
    };

    localparam int H_TOT = h_total(C_MODE);
    localparam int V_TOT = v_total(C_MODE);

    // Decode constants are one bit wider than the counters so a window ending exactly at 2^W still compares.
    localparam logic [X_W:0] C_H_LAST  = (X_W+1)'(H_TOT - 1);
    localparam logic [X_W:0] C_H_ACT   = (X_W+1)'(int'(C_MODE.h_active));
    localparam logic [X_W:0] C_HS_BEG  = (X_W+1)'(hs_start(C_MODE));
    localparam logic [X_W:0] C_HS_END  = (X_W+1)'(hs_end(C_MODE));
    localparam logic [Y_W:0] C_V_LAST  = (Y_W+1)'(V_TOT - 1);
    localparam logic [Y_W:0] C_V_ACT   = (Y_W+1)'(int'(C_MODE.v_active));
    localparam logic [Y_W:0] C_V_ACTM1 = (Y_W+1)'(int'(C_MODE.v_active) - 1);
    localparam logic [Y_W:0] C_VS_BEG  = (Y_W+1)'(vs_start(C_MODE));
    localparam logic [Y_W:0] C_VS_END  = (Y_W+1)'(vs_end(C_MODE));

    localparam logic [2:0] C_DLY_RST = {1'b0, ~C_MODE.hs_pol, ~C_MODE.vs_pol};

    generate
        if (H_TOT > (2 ** X_W)) begin : g_err_htot
            $error("vga_timing_gen: H_TOTAL %0d does not fit in X_W=%0d", H_TOT, X_W);
        end
        if (V_TOT > (2 ** Y_W)) begin : g_err_vtot
            $error("vga_timing_gen: V_TOTAL %0d does not fit in Y_W=%0d", V_TOT, Y_W);
        end
        if (H_SYNC == 0 || V_SYNC == 0) begin : g_err_sync
            $error("vga_timing_gen: sync widths must be non-zero");
        end
        if (PIPE_DELAY > 15) begin : g_err_dly
            $error("vga_timing_gen: PIPE_DELAY %0d exceeds 15", PIPE_DELAY);
        end
    endgenerate

    logic [X_W-1:0] r_h;
    logic [Y_W-1:0] r_v;
    logic [X_W-1:0] w_h_nxt;
    logic [Y_W-1:0] w_v_nxt;
    logic [X_W:0]   w_h_ext;
    logic [Y_W:0]   w_v_ext;
    logic           w_h_last;
    logic           w_v_last;
    logic           w_wrap;

    assign w_h_ext  = {1'b0, r_h};
    assign w_v_ext  = {1'b0, r_v};
    assign w_h_last = (w_h_ext == C_H_LAST);
    assign w_v_last = (w_v_ext == C_V_LAST);
    assign w_wrap   = w_h_last && w_v_last;

    always_comb begin
        w_h_nxt = r_h + 1'b1;
        w_v_nxt = r_v;
        if (w_h_last) begin
            w_h_nxt = '0;
            w_v_nxt = w_v_last ? '0 : r_v + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h <= '0;
            r_v <= '0;
        end else if (pix_en) begin
            r_h <= w_h_nxt;
            r_v <= w_v_nxt;
        end
    end

    // Strobes mark the tick that moved the counters, so they are cleared on any clk without pix_en.
    logic r_line_start;
    logic r_frame_start;
    logic r_vblank_start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_line_start   <= 1'b0;
            r_frame_start  <= 1'b0;
            r_vblank_start <= 1'b0;
        end else begin
            r_line_start   <= pix_en && w_h_last;
            r_frame_start  <= pix_en && w_wrap;
            r_vblank_start <= pix_en && w_h_last && (w_v_ext == C_V_ACTM1);
        end
    end

    logic       w_valid_raw;
    logic       w_hs_in;
    logic       w_vs_in;
    logic [2:0] w_raw;
    logic [2:0] w_dly;

    assign w_valid_raw = (w_h_ext < C_H_ACT) && (w_v_ext < C_V_ACT);
    assign w_hs_in     = (w_h_ext >= C_HS_BEG) && (w_h_ext < C_HS_END);
    assign w_vs_in     = (w_v_ext >= C_VS_BEG) && (w_v_ext < C_VS_END);
    assign w_raw       = {w_valid_raw,
                          w_hs_in ? C_MODE.hs_pol : ~C_MODE.hs_pol,
                          w_vs_in ? C_MODE.vs_pol : ~C_MODE.vs_pol};

    sync_delay_line #(
        .DEPTH     (int'(PIPE_DELAY) + 1),
        .WIDTH     (3),
        .RESET_VAL (C_DLY_RST)
    ) u_sync_dly (
        .i_clk (clk),
        .i_rst (rst),
        .i_en  (pix_en),
        .i_dat (w_raw),
        .o_dat (w_dly)
    );

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_cnt <= '0;
        end else if (pix_en && w_wrap) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`else
    assign frame_cnt = '0;
`endif

    assign beam_x       = r_h;
    assign beam_y       = r_v;
    assign valid        = w_dly[2];
    assign hsync        = w_dly[1];
    assign vsync        = w_dly[0];
    assign line_start   = r_line_start;
    assign frame_start  = r_frame_start;
    assign vblank_start = r_vblank_start;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator, the successor to the fixed-mode `beam_establisher`. It produces beam coordinates, the active-area flag, and HSYNC/VSYNC with a configurable mode and sync polarity. A pixel-clock enable lets one system clock serve several pixel rates. A configurable delay line aligns `valid` and the syncs with the downstream painter pipeline, and line, frame and vblank strobes drive game-logic ticks. It sits between the board clocking and `ultra_beam_substance_painter`/`doodle`/`platforms`.

## Interface
Parameters:
- H_ACTIVE, 1024: visible pixels per line
- H_FRONT, 24: horizontal front porch, pixels
- H_SYNC, 136: hsync width, pixels
- H_BACK, 160: horizontal back porch, pixels
- V_ACTIVE, 768: visible lines
- V_FRONT, 3: vertical front porch, lines
- V_SYNC, 6: vsync width, lines
- V_BACK, 29: vertical back porch, lines
- HS_POL, 0: active level of hsync
- VS_POL, 0: active level of vsync
- PIPE_DELAY, 0: extra pixel ticks of delay on valid/hsync/vsync (0..15)
- X_W, 11 / Y_W, 10: counter widths

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; asynchronous, active-high
- pix_en  in  1  pixel tick; counters and delay line advance only when 1
- beam_x  out  X_W  current horizontal count, undelayed
- beam_y  out  Y_W  current vertical count, undelayed
- valid  out  1  beam inside active area, delayed
- hsync  out  1  horizontal sync, delayed
- vsync  out  1  vertical sync, delayed
- line_start  out  1  one-clk strobe
- frame_start  out  1  one-clk strobe
- vblank_start  out  1  one-clk strobe
- frame_cnt  out  16  frame counter (see Configuration)

## Operation
- H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK. V_TOTAL is defined the same way.
- Counter advance, on clk with pix_en=1:
  - h increments; at H_TOTAL-1, h goes to 0 and v increments.
  - At (H_TOTAL-1, V_TOTAL-1) both counters go to 0.
  - beam_x/beam_y are the counter registers directly.
- Raw signals, decoded from the counters:
  - valid_raw = h<H_ACTIVE && v<V_ACTIVE
  - hs_raw active when H_ACTIVE+H_FRONT ≤ h < H_ACTIVE+H_FRONT+H_SYNC
  - vs_raw active when V_ACTIVE+V_FRONT ≤ v < V_ACTIVE+V_FRONT+V_SYNC
  - Active level is HS_POL/VS_POL; otherwise the complement.
- The raw signals are registered once on pix_en, then pass through PIPE_DELAY further pix_en-gated stages.
- Strobes are registered and high for exactly one clk, in the clk after the pix_en edge that moved the counters:
  - line_start: to h=0
  - frame_start: to (0,0)
  - vblank_start: to (0,V_ACTIVE)
  - Coincident strobes (line_start with frame_start) assert together.
- pix_en=0: all state frozen and strobes 0.
- Elaboration-time $error if H_TOTAL > 2^X_W, V_TOTAL > 2^Y_W, any SYNC = 0, or PIPE_DELAY > 15.

## Timing
- Reset values:
  - beam_x=0, beam_y=0, valid=0
  - hsync=~HS_POL, vsync=~VS_POL
  - all strobes 0, frame_cnt=0
  - all delay stages hold the inactive values
- No strobe is issued on reset release; the first frame_start comes at the first full frame wrap.
- Latency of valid/hsync/vsync relative to beam_x/beam_y is 1+PIPE_DELAY pix_en ticks.
- rst mid-frame clears everything immediately, and the delay line is flushed to inactive values.
- The first pix_en after release advances to h=1.

## Configuration
- VGA_TIMING_FRAME_CNT_EN defined: frame_cnt increments by 1 on every frame_start and wraps from 65535 to 0.
- Not defined: frame_cnt is tied to 0 and no counter flops are generated. The port is present either way.

## Structure
- Package vga_timing_pkg holds:
  - typedef struct vga_mode_t (the eight timing fields plus the two polarities)
  - localparams MODE_1024X768_60 and MODE_640X480_60
  - The parent passes mode fields as parameters.
- Sub-module sync_delay_line: parametrised DEPTH×WIDTH shift register with enable and async reset to a RESET_VAL parameter. It is used for {valid, hsync, vsync}.

## Test plan
Small mode for all tests: H 8/2/2/2 (H_TOTAL 14), V 4/1/1/1 (V_TOTAL 7), negative polarity, pix_en=1 unless stated.
- Reset: hold rst → beam_x=0, beam_y=0, valid=0, hsync=1, vsync=1, strobes 0.
- Steady run:
  - valid is high for 8 of every 14 clks on lines 0–3 and low on lines 4–6.
  - hsync is low while delayed h=10,11; vsync is low for delayed v=5.
  - line_start period is 14 clk; frame_start period is 98 clk; vblank_start is 56 clk after frame_start.
- pix_en every other clk: frame_start period is 196 clk, each strobe exactly 1 clk wide, state unchanged while pix_en=0.
- PIPE_DELAY=2 vs 0: valid/hsync/vsync edges lag by exactly 2 pix_en ticks; beam_x/beam_y are identical.
- rst pulse at (h=5, v=2): outputs return to reset values in the same cycle; h=1, v=0 after the next pix_en; no spurious strobe.
- With VGA_TIMING_FRAME_CNT_EN: frame_cnt=3 after 3 frames, and preload 65535 then one frame gives 0. Without the macro, frame_cnt stays 0.
